// File: rtl/controle_dispensa_pkg.sv
// Shared definitions for the vending dispense controller.
//   estado_t  : FSM state encoding
//   ERRO_*    : codes reported on the erro bus
//   max_int   : helper for sizing the shared timer
package controle_dispensa_pkg;

  typedef enum logic [2:0] {
    ESPERA  = 3'd0,
    VALIDA  = 3'd1,
    MOTOR   = 3'd2,
    CONCLUI = 3'd3,
    ERRO    = 3'd4
  } estado_t;

  localparam logic [1:0] ERRO_NENHUM = 2'b00;
  localparam logic [1:0] ERRO_SLOT   = 2'b01;
  localparam logic [1:0] ERRO_SALDO  = 2'b10;
  localparam logic [1:0] ERRO_TRAVA  = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/controle_dispensa_if.sv
// Digit-selection handshake between the selection controller (master) and
// the dispense controller (slave).
//   valido/linha/coluna/preco/credito : completed selection from master
//   ok/erro/ocupado                   : transaction status from slave
interface controle_dispensa_if;
  logic       valido;
  logic [1:0] linha;
  logic [1:0] coluna;
  logic [7:0] preco;
  logic [7:0] credito;
  logic       ok;
  logic [1:0] erro;
  logic       ocupado;

  modport master (
    output valido, linha, coluna, preco, credito,
    input  ok, erro, ocupado
  );

  modport slave (
    input  valido, linha, coluna, preco, credito,
    output ok, erro, ocupado
  );
endinterface

// File: rtl/controle_dispensa_temporizador.sv
// Up-counter with synchronous clear, enable and a terminal-count flag at a
// runtime limit. Saturates at the limit.
//   clr_i    : clear to zero (wins over enable)
//   en_i     : count enable
//   limite_i : terminal count value
//   cnt_o    : current count
//   fim_o    : count equals limite_i
module controle_dispensa_temporizador #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limite_i,
  output logic [W-1:0] cnt_o,
  output logic         fim_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !fim_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign fim_o = (cnt_q == limite_i);

endmodule

// File: rtl/controle_dispensa.sv
// Dispense controller: validates a selection, runs the slot motor until the
// drop sensor fires or the motor times out, debits credit and pulses ok.
//   clk, rst_n      : clock, async active-low reset
//   sel             : selection handshake (slave side)
//   sensor_queda_i  : product-drop sensor
//   reabastecer_i   : refill all slots (honoured only when idle)
//   motor_ativo_o   : motor drive
//   motor_slot_o    : {linha,coluna} of the driven slot
//   debitar_o       : one-cycle debit pulse
//   valor_debito_o  : debit amount, valid with debitar_o
//
// state   | meaning
// ESPERA  | idle, waiting for a selection or refill
// VALIDA  | check slot index, stock and credit
// MOTOR   | motor running, waiting for drop sensor or timeout
// CONCLUI | debit, ok pulse, stock decrement
// ERRO    | hold error code, ok on the last cycle
module controle_dispensa
  import controle_dispensa_pkg::*;
#(
  parameter int N_LINHAS        = 4,
  parameter int N_COLUNAS       = 4,
  parameter int ESTOQUE_INICIAL = 5,
  parameter int TEMPO_MOTOR     = 50,
  parameter int TEMPO_ERRO      = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  controle_dispensa_if.slave   sel,
  input  logic                 sensor_queda_i,
  input  logic                 reabastecer_i,
  output logic                 motor_ativo_o,
  output logic [3:0]           motor_slot_o,
  output logic                 debitar_o,
  output logic [7:0]           valor_debito_o
);

  localparam int TW = $clog2(max_int(TEMPO_MOTOR, TEMPO_ERRO)) + 1;

  estado_t     estado_q;
  logic [1:0]  linha_q, coluna_q;
  logic [7:0]  preco_q, credito_q;
  logic [2:0]  estoque_q [16];
  logic        motor_q;
  logic [3:0]  slot_q;
  logic        debitar_q;
  logic [7:0]  valor_q;
  logic        ok_q;
  logic [1:0]  erro_q;

  logic [TW-1:0] limite, cnt;
  logic          fim, tmr_clr, tmr_en;
  logic [3:0]    idx;

  assign idx = {linha_q, coluna_q};

  // Timer runs only in MOTOR and ERRO; it is cleared everywhere else and on
  // the MOTOR->ERRO timeout edge so ERRO starts counting from zero.
  assign tmr_en  = (estado_q == MOTOR) || (estado_q == ERRO);
  assign tmr_clr = !tmr_en || ((estado_q == MOTOR) && fim);
  assign limite  = (estado_q == MOTOR) ? TW'(TEMPO_MOTOR - 1) : TW'(TEMPO_ERRO - 1);

  controle_dispensa_temporizador #(.W(TW)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .limite_i (limite),
    .cnt_o    (cnt),
    .fim_o    (fim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= ESPERA;
      linha_q   <= '0;
      coluna_q  <= '0;
      preco_q   <= '0;
      credito_q <= '0;
      motor_q   <= 1'b0;
      slot_q    <= '0;
      debitar_q <= 1'b0;
      valor_q   <= '0;
      ok_q      <= 1'b0;
      erro_q    <= ERRO_NENHUM;
      for (int i = 0; i < 16; i++) estoque_q[i] <= 3'(ESTOQUE_INICIAL);
    end else begin
      debitar_q <= 1'b0;
      valor_q   <= '0;
      ok_q      <= 1'b0;
      case (estado_q)
        ESPERA: begin
          if (sel.valido) begin
            linha_q   <= sel.linha;
            coluna_q  <= sel.coluna;
            preco_q   <= sel.preco;
            credito_q <= sel.credito;
            estado_q  <= VALIDA;
          end else if (reabastecer_i) begin
            for (int i = 0; i < 16; i++) estoque_q[i] <= 3'(ESTOQUE_INICIAL);
          end
        end
        VALIDA: begin
          if (int'(linha_q) >= N_LINHAS || int'(coluna_q) >= N_COLUNAS) begin
            erro_q   <= ERRO_SLOT;
            estado_q <= ERRO;
          end else if (estoque_q[idx] == 3'd0 || credito_q < preco_q) begin
            erro_q   <= ERRO_SALDO;
            estado_q <= ERRO;
          end else begin
            motor_q  <= 1'b1;
            slot_q   <= idx;
            estado_q <= MOTOR;
          end
        end
        MOTOR: begin
          // Sensor has priority over a timeout in the same cycle.
          if (sensor_queda_i) begin
            motor_q   <= 1'b0;
            slot_q    <= '0;
            debitar_q <= 1'b1;
            valor_q   <= preco_q;
            ok_q      <= 1'b1;
            estado_q  <= CONCLUI;
          end else if (fim) begin
            motor_q  <= 1'b0;
            slot_q   <= '0;
            erro_q   <= ERRO_TRAVA;
            estado_q <= ERRO;
          end
        end
        CONCLUI: begin
          if (estoque_q[idx] != 3'd0) estoque_q[idx] <= estoque_q[idx] - 3'd1;
          estado_q <= ESPERA;
        end
        ERRO: begin
          if (fim) begin
            erro_q   <= ERRO_NENHUM;
            estado_q <= ESPERA;
          end else if (cnt == TW'(TEMPO_ERRO - 2)) begin
            // Registered ok lands on the final error cycle.
            ok_q <= 1'b1;
          end
        end
        default: estado_q <= ESPERA;
      endcase
    end
  end

  assign sel.ok         = ok_q;
  assign sel.erro       = erro_q;
  assign sel.ocupado    = (estado_q != ESPERA);
  assign motor_ativo_o  = motor_q;
  assign motor_slot_o   = slot_q;
  assign debitar_o      = debitar_q;
  assign valor_debito_o = valor_q;

endmodule
